config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// config_loader
//   Streams host configuration words into a serial config_cell chain, LSB
//   first, and captures the bits falling out of the far end of the chain so
//   the previous contents can be read back while a new image is loaded.
//
// Parameters
//   size       configuration word width in bits
//   CHAIN_LEN  total number of cells in the chain (>= 1)
//
// Ports
//   config_clk    sole clock, rising edge
//   config_reset  synchronous reset, active low
//   start         begin a full-chain load (only looked at while idle)
//   abort         cancel a load in progress
//   wdata/wvalid  host word and its valid; wready marks the accepting cycle
//   cfg_bit       serial data to the first cell
//   cfg_shift_en  chain shift strobe (gates the chain's config clock)
//   cfg_return    last cell's output, sampled for readback
//   rdata/rvalid  readback word (LSB = first returned bit), one-cycle valid
//   busy          high whenever a load is in progress
//   done          one-cycle pulse when the whole chain has been written

module config_loader #(
  parameter int size      = 32,
  parameter int CHAIN_LEN = 96
) (
  input  logic            config_clk,
  input  logic            config_reset,
  input  logic            start,
  input  logic            abort,
  input  logic [size-1:0] wdata,
  input  logic            wvalid,
  output logic            wready,
  output logic            cfg_bit,
  output logic            cfg_shift_en,
  input  logic            cfg_return,
  output logic [size-1:0] rdata,
  output logic            rvalid,
  output logic            busy,
  output logic            done
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(size + 1);
  localparam int RW = (size > 1) ? $clog2(size) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [RW-1:0] LAST_POS = RW'(size - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state_reg;
  logic [size-1:0] sreg_reg;
  logic [BW-1:0]   bitcnt_reg;
  logic [WW-1:0]   wbits_reg;
  logic [RW-1:0]   rpos_reg;
  logic [size-1:0] acc_reg;
  logic [size-1:0] rdata_reg;
  logic            rvalid_reg;

  logic [size-1:0] acc_next;
  logic [31:0]     remaining;
  logic [WW-1:0]   wbits_load;
  logic            last_chain_bit;
  logic            word_full;

  // Bits still owed to the chain decide how much of the next word is used;
  // the final word of a non-multiple chain keeps only its low bits.
  assign remaining  = 32'(CHAIN_LEN) - 32'(bitcnt_reg);
  assign wbits_load = (remaining > 32'(size)) ? WW'(size) : WW'(remaining);

  assign last_chain_bit = (bitcnt_reg == LAST_BIT);
  assign word_full      = (rpos_reg == LAST_POS);

  // Returned bit lands at the position given by how many bits of the current
  // readback word have already come back.
  for (genvar gi = 0; gi < size; gi++) begin : g_acc
    assign acc_next[gi] = (rpos_reg == RW'(gi)) ? cfg_return : acc_reg[gi];
  end

  always_ff @(posedge config_clk) begin
    if (!config_reset) begin
      state_reg  <= IDLE;
      sreg_reg   <= '0;
      bitcnt_reg <= '0;
      wbits_reg  <= '0;
      rpos_reg   <= '0;
      acc_reg    <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            state_reg  <= LOAD;
            bitcnt_reg <= '0;
            rpos_reg   <= '0;
            acc_reg    <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (wvalid) begin
            sreg_reg  <= wdata;
            wbits_reg <= wbits_load;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            // The strobe is suppressed this cycle, so the bit being returned
            // is not captured and no partial readback word is released.
            state_reg <= IDLE;
          end else begin
            sreg_reg   <= sreg_reg >> 1;
            bitcnt_reg <= bitcnt_reg + BW'(1);
            wbits_reg  <= wbits_reg - WW'(1);
            if (word_full || last_chain_bit) begin
              rdata_reg  <= acc_next;
              rvalid_reg <= 1'b1;
              acc_reg    <= '0;
              rpos_reg   <= '0;
            end else begin
              acc_reg  <= acc_next;
              rpos_reg <= rpos_reg + RW'(1);
            end
            if (wbits_reg == WW'(1)) begin
              state_reg <= last_chain_bit ? DONE : LOAD;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // abort masks the handshake, strobe and completion in the very cycle it is
  // raised, so nothing moves while the loader is being cancelled.
  assign busy         = (state_reg != IDLE);
  assign wready       = (state_reg == LOAD) && !abort;
  assign cfg_shift_en = (state_reg == SHIFT) && !abort;
  assign cfg_bit      = cfg_shift_en && sreg_reg[0];
  assign done         = (state_reg == DONE) && !abort;
  assign rdata        = rdata_reg;
  assign rvalid       = rvalid_reg;

endmodule
